// File: rtl/univ_shifter.sv
`default_nettype none
// ============================================================================
// Module      : univ_shifter
// Description : Universal shift register. Supports parallel load, single-step
//               shifts and multi-cycle shifts in logical, arithmetic and
//               rotate modes.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   in_value,
    input  logic               right,
    input  logic               left,
    input  logic [1:0]         mode,
    input  logic               ser_in,
    input  logic               start,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   value,
    output logic               ser_out,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [1:0] c_MODE_ARITH  = 2'b01;
    localparam logic [1:0] c_MODE_ROTATE = 2'b10;

    logic [0:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_value;
    logic               r_ser_out;
    logic               r_busy;
    logic               r_done;

    logic               w_dir;
    logic [1:0]         w_mode;
    logic               w_fill;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_shift_out;

    // A running multi-cycle shift uses the direction/mode captured at start.
    assign w_dir  = (r_state == S_SHIFT) ? r_dir  : right;
    assign w_mode = (r_state == S_SHIFT) ? r_mode : mode;

    always_comb begin
        w_fill      = ser_in;
        w_shifted   = r_value;
        w_shift_out = 1'b0;
        if (w_dir) begin
            if (w_mode == c_MODE_ARITH)
                w_fill = r_value[WIDTH-1];
            else if (w_mode == c_MODE_ROTATE)
                w_fill = r_value[0];
            w_shifted   = {w_fill, r_value[WIDTH-1:1]};
            w_shift_out = r_value[0];
        end else begin
            if (w_mode == c_MODE_ARITH)
                w_fill = 1'b0;
            else if (w_mode == c_MODE_ROTATE)
                w_fill = r_value[WIDTH-1];
            w_shifted   = {r_value[WIDTH-2:0], w_fill};
            w_shift_out = r_value[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_mode    <= 2'b00;
            r_value   <= '0;
            r_ser_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_value <= in_value;
                    end else if (start) begin
                        if (amount == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= amount;
                            r_dir   <= right;
                            r_mode  <= mode;
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end else if (right != left) begin
                        r_value   <= w_shifted;
                        r_ser_out <= w_shift_out;
                    end
                end
                default: begin
                    if (load) begin
                        // Abort: no done pulse for an interrupted operation.
                        r_value <= in_value;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_value   <= w_shifted;
                        r_ser_out <= w_shift_out;
                        r_cnt     <= r_cnt - SHAMT_W'(1);
                        if (r_cnt == SHAMT_W'(1)) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign value   = r_value;
    assign ser_out = r_ser_out;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shifter
// Description : Self-checking bench for univ_shifter (WIDTH=8, SHAMT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shifter;

    logic       clk = 1'b0;
    logic       rst, load, right, left, ser_in, start;
    logic [7:0] in_value;
    logic [1:0] mode;
    logic [2:0] amount;
    logic [7:0] value;
    logic       ser_out, busy, done;

    univ_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk(clk), .rst(rst), .load(load), .in_value(in_value),
        .right(right), .left(left), .mode(mode), .ser_in(ser_in),
        .start(start), .amount(amount), .value(value),
        .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] value;
        logic       ser_out;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    // Reference model state
    logic [7:0] m_value = '0;
    logic       m_ser = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_dir = 1'b0;
    logic [1:0] m_mode = '0;
    int         m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_shift(input logic [7:0] v, input logic dir,
                                             input logic [1:0] md, input logic si);
        logic [7:0] r;
        if (dir) begin
            case (md)
                2'b01:   r = 8'($signed(v) >>> 1);
                2'b10:   r = (v >> 1) | (v << 7);
                default: r = (v >> 1) | {si, 7'b0};
            endcase
            return {v[0], r};
        end
        case (md)
            2'b01:   r = v << 1;
            2'b10:   r = (v << 1) | (v >> 7);
            default: r = (v << 1) | {7'b0, si};
        endcase
        return {v[7], r};
    endfunction

    task automatic model_step();
        logic [8:0] s;
        if (rst) begin
            m_value = '0; m_ser = 0; m_busy = 0; m_done = 0; m_cnt = 0;
            return;
        end
        m_done = 0;
        if (!m_busy) begin
            if (load) m_value = in_value;
            else if (start) begin
                if (amount == 0) m_done = 1;
                else begin
                    m_cnt = amount; m_dir = right; m_mode = mode; m_busy = 1;
                end
            end else if (right ^ left) begin
                s = ref_shift(m_value, right, mode, ser_in);
                m_ser = s[8]; m_value = s[7:0];
            end
        end else if (load) begin
            m_value = in_value; m_busy = 0; m_cnt = 0;
        end else begin
            s = ref_shift(m_value, m_dir, m_mode, ser_in);
            m_ser = s[8]; m_value = s[7:0];
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    // Drive one cycle: push the model's expectation, clock, pop and compare.
    task automatic cyc(input string tag, input logic r, input logic ld, input logic [7:0] d,
                       input logic rt, input logic lt, input logic [1:0] md,
                       input logic si, input logic st, input logic [2:0] am);
        exp_t e;
        rst = r; load = ld; in_value = d; right = rt; left = lt;
        mode = md; ser_in = si; start = st; amount = am;
        model_step();
        exp_q.push_back('{tag, m_value, m_ser, m_busy, m_done});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".value"},   32'(value),   32'(e.value));
        check({e.tag, ".ser_out"}, 32'(ser_out), 32'(e.ser_out));
        check({e.tag, ".busy"},    32'(busy),    32'(e.busy));
        check({e.tag, ".done"},    32'(done),    32'(e.done));
        if (done === 1'b1) done_seen++;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 3'd0);
    endtask

    initial begin
        // Case 1: reset
        cyc("rst0", 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 3'd0);
        cyc("rst1", 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 3'd0);
        check("c1_value", 32'(value), 32'h00);
        check("c1_busy_done", 32'({ser_out, busy, done}), 32'h0);

        // Case 2: logical left with ser_in=1
        cyc("c2_load", 0, 1, 8'hA5, 0, 0, 2'b00, 0, 0, 3'd0);
        cyc("c2_left", 0, 0, 8'h00, 0, 1, 2'b00, 1, 0, 3'd0);
        check("c2_value", 32'(value), 32'h4B);
        check("c2_ser_out", 32'(ser_out), 32'h1);

        // Case 3: arithmetic right by 3
        cyc("c3_load", 0, 1, 8'h81, 0, 0, 2'b00, 0, 0, 3'd0);
        done_seen = 0;
        cyc("c3_start", 0, 0, 8'h00, 1, 0, 2'b01, 0, 1, 3'd3);
        check("c3_start_hold", 32'(value), 32'h81);
        idle("c3_s1"); check("c3_v1", 32'(value), 32'hC0);
        idle("c3_s2"); check("c3_v2", 32'(value), 32'hE0);
        idle("c3_s3"); check("c3_v3", 32'(value), 32'hF0);
        check("c3_ser_out", 32'(ser_out), 32'h0);
        check("c3_busy_off", 32'(busy), 32'h0);
        idle("c3_after");
        check("c3_done_count", 32'(done_seen), 32'd1);

        // Case 4: rotate right by 2, then right=left=1 holds
        cyc("c4_load", 0, 1, 8'h01, 0, 0, 2'b00, 0, 0, 3'd0);
        cyc("c4_start", 0, 0, 8'h00, 1, 0, 2'b10, 0, 1, 3'd2);
        idle("c4_s1");
        idle("c4_s2");
        check("c4_value", 32'(value), 32'h40);
        check("c4_ser_out", 32'(ser_out), 32'h0);
        cyc("c4_both", 0, 0, 8'h00, 1, 1, 2'b00, 1, 0, 3'd0);
        check("c4_hold", 32'(value), 32'h40);

        // Case 5: load aborts a 5-step shift on the 2nd busy cycle
        done_seen = 0;
        cyc("c5_start", 0, 0, 8'h00, 0, 0, 2'b00, 0, 1, 3'd5);
        idle("c5_b1");
        cyc("c5_abort", 0, 1, 8'h3C, 0, 0, 2'b00, 0, 0, 3'd0);
        check("c5_value", 32'(value), 32'h3C);
        check("c5_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 6; i++) idle("c5_idle");
        check("c5_no_done", 32'(done_seen), 32'd0);

        // Case 6: reset mid-shift, then start with amount 0
        cyc("c6_start", 0, 0, 8'h00, 1, 0, 2'b00, 1, 1, 3'd4);
        idle("c6_s1");
        done_seen = 0;
        cyc("c6_rst", 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 3'd0);
        check("c6_rst_all", 32'({value, ser_out, busy, done}), 32'h0);
        for (int i = 0; i < 4; i++) idle("c6_idle");
        check("c6_no_done", 32'(done_seen), 32'd0);
        cyc("c6_zero", 0, 0, 8'h00, 1, 0, 2'b01, 1, 1, 3'd0);
        check("c6_done", 32'(done), 32'h1);
        check("c6_value", 32'(value), 32'h00);
        idle("c6_after");
        check("c6_done_once", 32'(done_seen), 32'd1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/univ_shifter.md
UNIV_SHIFTER -- requirements
Module: univ_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits (minimum 2).
REQ-002 SHALL have parameter SHAMT_W, default 3: width of the multi-cycle shift amount.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  parallel load of in_value.
REQ-006 SHALL have port in_value  input  WIDTH  parallel load data.
REQ-007 SHALL have port right  input  1  single-step right shift; also selects direction at start (1=right, 0=left).
REQ-008 SHALL have port left  input  1  single-step left shift.
REQ-009 SHALL have port mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical.
REQ-010 SHALL have port ser_in  input  1  fill bit for the vacated position in logical mode.
REQ-011 SHALL have port start  input  1  launch a multi-cycle shift of amount positions.
REQ-012 SHALL have port amount  input  SHAMT_W  number of positions for a start operation.
REQ-013 SHALL have port value  output  WIDTH  registered shift register contents.
REQ-014 SHALL have port ser_out  output  1  registered bit shifted out by the most recent shift.
REQ-015 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse marking the end of a start operation.

Function
REQ-017 SHALL implement the FSM states IDLE and SHIFT, plus a remaining-count register of width SHAMT_W.
REQ-018 IDLE priority, highest first, SHALL be: load, start, right-only, left-only, hold; right=left=1 SHALL hold value.
REQ-019 Logical shift SHALL fill the vacated bit with ser_in; arithmetic right SHALL replicate the MSB; arithmetic left SHALL fill with 0; rotate SHALL wrap the shifted-out bit into the vacated position.
REQ-020 Every shift (single-step or multi-cycle) SHALL update ser_out to the bit leaving the register (LSB for right, MSB for left); ser_out SHALL hold otherwise, including on load.
REQ-021 On start in IDLE with amount=N>0: latch direction (from right) and mode, cnt<=N, go to SHIFT, set busy=1, with no shift on this edge.
REQ-022 In SHIFT, each edge SHALL perform one shift and decrement cnt; the edge where cnt==1 SHALL shift, return to IDLE, clear busy, and set done=1 for exactly one cycle.
REQ-023 Net effect: busy high for N cycles, N shifts, done visible in cycle N+1 after the start edge.
REQ-024 start with amount=0 SHALL leave value unchanged, stay IDLE, and pulse done in the next cycle.
REQ-025 In SHIFT, right, left, start, mode and amount SHALL be ignored.
REQ-026 load in SHIFT SHALL load in_value, abort to IDLE, clear busy, and produce no done pulse.
REQ-027 done SHALL be 0 in every cycle other than those specified in REQ-022 and REQ-024.

Reset
REQ-028 rst SHALL take priority over all inputs, including during SHIFT.
REQ-029 rst SHALL set value=0, ser_out=0, busy=0, done=0, cnt=0 and state=IDLE on the next edge, and SHALL suppress any pending done.

Verification (WIDTH=8, SHAMT_W=3)
REQ-030 Case 1, rst for 2 cycles -> value=8'h00, ser_out=0, busy=0, done=0.
REQ-031 Case 2, load 8'hA5, then left=1, mode=00, ser_in=1 for one cycle -> value=8'h4B, ser_out=1.
REQ-032 Case 3, load 8'h81, then start, right=1, mode=01, amount=3 -> value C0, E0, F0 on successive edges, busy high 3 cycles, done pulses once, ser_out=0.
REQ-033 Case 4, load 8'h01, then start, right=1, mode=10, amount=2 -> final value=8'h40, ser_out=0; then right=left=1 -> value holds 8'h40.
REQ-034 Case 5, start with amount=5, then load 8'h3C on the 2nd busy cycle -> value=8'h3C, busy=0, done never asserted.
REQ-035 Case 6, rst asserted mid-SHIFT, then start with amount=0 -> all outputs 0 with no done, then a single done pulse and value unchanged.
